wr_ptr_level_ctrl: RTL and testbench
====================================

// Module: wr_ptr_level_ctrl
// PURPOSE
//  Write-domain pointer/flag controller for an async dual-clock FIFO.
//  Generates the write address and the registered Gray write pointer (to be synchronised into the read domain).
//  From the read pointer already synchronised into wr_clk it also produces: full, programmable almost-full,
//  fill level, a registered write acknowledge and a sticky overflow error.
//  Sits between the FIFO write client and the dual-port RAM write port.
// PARAMETERS
//  ADDR_WIDTH  5  RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range >= 2
// PORTS
//  wr_clk          in   1             write-domain clock
//  reset           in   1             asynchronous, active-high reset
//  wr_en           in   1             write request
//  sync_read_ptr   in   ADDR_WIDTH+1  Gray read pointer, already synchronised into wr_clk
//  afull_thresh    in   ADDR_WIDTH+1  almost-full threshold in words; quasi-static
//  ovf_clr         in   1             clears wr_overflow
//  wr_address      out  ADDR_WIDTH    RAM write address = wr_bin_ptr[ADDR_WIDTH-1:0]
//  wr_ptr          out  ADDR_WIDTH+1  registered Gray write pointer
//  wr_full         out  1             registered full flag
//  wr_almost_full  out  1             registered, wr_level >= afull_thresh
//  wr_level        out  ADDR_WIDTH+1  registered fill count, 0..2**ADDR_WIDTH
//  wr_ack          out  1             registered; 1 in the cycle after an accepted write
//  wr_overflow     out  1             sticky; a write was attempted while full
// BEHAVIOUR
//  - Reset (async): wr_bin_ptr, wr_ptr, wr_full, wr_almost_full, wr_level, wr_ack and wr_overflow all go to 0.
//  - Write acceptance and next pointers:
//      push = wr_en & ~wr_full
//      bin_next = wr_bin_ptr + push   (mod 2**(ADDR_WIDTH+1); natural wrap)
//      gray_next = bin_next ^ (bin_next >> 1)
//  - On every wr_clk edge: wr_bin_ptr <= bin_next; wr_ptr <= gray_next.
//      No internal state beyond these registers and the flags below.
//  - RAM write: data is written at the current wr_address in the cycle push = 1.
//  - Full flag:
//      full_next = (gray_next == {~sync_read_ptr[AW:AW-1], sync_read_ptr[AW-2:0]})
//      wr_full <= full_next; latency 0 beyond the register
//      (the flag is valid in the same cycle wr_ptr updates).
//  - Level:
//      rd_bin = Gray-to-binary(sync_read_ptr), combinational XOR prefix
//      wr_level <= bin_next - rd_bin   (mod 2**(ADDR_WIDTH+1)); never exceeds 2**ADDR_WIDTH
//  - Almost full:
//      wr_almost_full <= ((bin_next - rd_bin) >= afull_thresh)
//      afull_thresh = 0 drives the flag to 1 from the first edge after reset.
//  - Ack: wr_ack <= push.
//  - Overflow: wr_overflow <= (wr_en & wr_full) | (wr_overflow & ~ovf_clr).
//      If a set and ovf_clr occur in the same cycle, the set wins.
//      A write while full leaves the pointer unchanged and the RAM unwritten.
//  - Read-pointer lag: flags and level are pessimistic.
//      full, almost-full and level may stay high or large for the synchroniser latency after reads.
//      They never indicate less occupancy than actual.
//  - Simultaneous write and read-pointer advance: both are folded into the same next-state computation.
//      Example: a full FIFO with one read seen and one write accepted remains full.
//  - Reset mid-operation: all outputs clear immediately (async); the pointer restarts at 0.
//      Both FIFO domains must be reset together.
// TESTING  (ADDR_WIDTH=3, depth 8, afull_thresh=6 unless stated)
//  1. Reset; sync_read_ptr=0; hold wr_en=1 for 8 cycles.
//     -> wr_ack high 8 cycles; wr_level counts 1..8; wr_almost_full rises when wr_level=6.
//     -> wr_full=1 with wr_level=8 and wr_ptr=4'b1100; wr_address stops at 0.
//  2. Continue from 1: wr_en=1 for 2 more cycles.
//     -> wr_ptr holds 4'b1100; wr_ack=0; wr_overflow=1 and stays 1.
//     -> pulse ovf_clr with wr_en=0 -> wr_overflow=0 next cycle.
//  3. Continue from 2: set sync_read_ptr=4'b0011 (bin 2), wr_en=0.
//     -> next cycle wr_full=0, wr_level=6, wr_almost_full=1.
//     -> set afull_thresh=7 -> wr_almost_full=0.
//  4. Wrap: with sync_read_ptr tracking wr_ptr two cycles late, write 20 words.
//     -> wr_ptr follows the Gray sequence through 4'b1000 (bin 15) to 4'b0000.
//     -> wr_address wraps 7->0; wr_full never asserts; wr_level stays <= 2.
//  5. Same-cycle overflow set and clear: while full, assert wr_en=1 and ovf_clr=1 together -> wr_overflow=1.
//  6. Reset mid-fill: after 5 writes, assert reset asynchronously between clock edges.
//     -> all outputs 0 immediately.
//     -> after release, first write goes to wr_address=0 and wr_ptr becomes 4'b0001.

Source files
------------

// File: rtl/wr_ptr_level_ctrl_if.sv
// Write-side bundle of the async FIFO pointer controller: client requests and
// read-pointer inputs in, address/pointer/flags out.
interface wr_ptr_level_ctrl_if #(
   parameter int ADDR_WIDTH = 5
);
   logic                  wr_en;
   logic [ADDR_WIDTH:0]   sync_read_ptr;
   logic [ADDR_WIDTH:0]   afull_thresh;
   logic                  ovf_clr;
   logic [ADDR_WIDTH-1:0] wr_address;
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic                  wr_full;
   logic                  wr_almost_full;
   logic [ADDR_WIDTH:0]   wr_level;
   logic                  wr_ack;
   logic                  wr_overflow;

   modport master (
      output wr_en, sync_read_ptr, afull_thresh, ovf_clr,
      input  wr_address, wr_ptr, wr_full, wr_almost_full, wr_level, wr_ack, wr_overflow
   );

   modport slave (
      input  wr_en, sync_read_ptr, afull_thresh, ovf_clr,
      output wr_address, wr_ptr, wr_full, wr_almost_full, wr_level, wr_ack, wr_overflow
   );
endinterface

// File: rtl/wr_ptr_level_ctrl.sv
// Write-domain pointer and flag controller for an async dual-clock FIFO.
// Produces the RAM write address, the Gray write pointer and full/level/ack/overflow status.
module wr_ptr_level_ctrl #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic              wr_clk,
   input  logic              reset,
   wr_ptr_level_ctrl_if.slave bus
);
   localparam int PW = ADDR_WIDTH + 1;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down recovers the binary value.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] r_bin_ptr;
   logic [PW-1:0] r_gray_ptr;
   logic          r_full;
   logic          r_afull;
   logic [PW-1:0] r_level;
   logic          r_ack;
   logic          r_ovf;

   logic          w_push;
   logic [PW-1:0] w_bin_next;
   logic [PW-1:0] w_gray_next;
   logic [PW-1:0] w_rd_bin;
   logic [PW-1:0] w_level_next;
   logic          w_full_next;
   logic          w_afull_next;
   logic          w_ovf_next;

   // Next pointer and flag values; write and read-pointer advance fold into one step.
   always_comb begin
      w_push       = bus.wr_en & ~r_full;
      w_bin_next   = r_bin_ptr + {{(PW-1){1'b0}}, w_push};
      w_gray_next  = bin2gray(w_bin_next);
      w_rd_bin     = gray2bin(bus.sync_read_ptr);
      w_level_next = w_bin_next - w_rd_bin;
      // Full when the pointers differ only in the two Gray MSBs (one lap ahead).
      w_full_next  = (w_gray_next == {~bus.sync_read_ptr[PW-1:PW-2], bus.sync_read_ptr[PW-3:0]});
      w_afull_next = (w_level_next >= bus.afull_thresh);
      w_ovf_next   = (bus.wr_en & r_full) | (r_ovf & ~bus.ovf_clr);
   end

   // Pointer, flag and status registers.
   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         r_bin_ptr  <= {PW{1'b0}};
         r_gray_ptr <= {PW{1'b0}};
         r_full     <= 1'b0;
         r_afull    <= 1'b0;
         r_level    <= {PW{1'b0}};
         r_ack      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_bin_ptr  <= w_bin_next;
         r_gray_ptr <= w_gray_next;
         r_full     <= w_full_next;
         r_afull    <= w_afull_next;
         r_level    <= w_level_next;
         r_ack      <= w_push;
         r_ovf      <= w_ovf_next;
      end
   end

   assign bus.wr_address     = r_bin_ptr[ADDR_WIDTH-1:0];
   assign bus.wr_ptr         = r_gray_ptr;
   assign bus.wr_full        = r_full;
   assign bus.wr_almost_full = r_afull;
   assign bus.wr_level       = r_level;
   assign bus.wr_ack         = r_ack;
   assign bus.wr_overflow    = r_ovf;
endmodule

// File: tb/tb_wr_ptr_level_ctrl.sv
// Directed bench for wr_ptr_level_ctrl (ADDR_WIDTH=3) with an occupancy-count
// reference model checked every cycle plus hand-computed literal checks.
module tb_wr_ptr_level_ctrl;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic wr_clk;
   logic reset;
   int   rd_count;
   bit   chk_en;
   int   n_cmp;
   int   n_fail;

   int   m_writes;
   int   m_level;
   bit   m_full;
   bit   m_afull;
   bit   m_ack;
   bit   m_ovf;

   int   gray_tab [16];

   wr_ptr_level_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   wr_ptr_level_ctrl #(.ADDR_WIDTH(AW)) dut (
      .wr_clk (wr_clk),
      .reset  (reset),
      .bus    (bus)
   );

   function automatic logic [AW:0] to_gray(input int n);
      int b;
      b = n % 16;
      return 4'(b ^ (b >> 1));
   endfunction

   assign bus.sync_read_ptr = to_gray(rd_count);

   initial begin
      wr_clk = 1'b0;
      forever #5 wr_clk = ~wr_clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_push();
      return bus.wr_en && !m_full;
   endfunction

   function automatic int m_occ_next();
      return m_writes + int'(m_push()) - rd_count;
   endfunction

   // Reference model: occupancy is writes accepted minus reads seen.
   always @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         m_writes <= 0;
         m_level  <= 0;
         m_full   <= 1'b0;
         m_afull  <= 1'b0;
         m_ack    <= 1'b0;
         m_ovf    <= 1'b0;
      end else begin
         m_writes <= m_writes + int'(m_push());
         m_level  <= m_occ_next();
         m_full   <= (m_occ_next() == DEPTH);
         m_afull  <= (m_occ_next() >= int'(bus.afull_thresh));
         m_ack    <= m_push();
         m_ovf    <= (bus.wr_en && m_full) || (m_ovf && !bus.ovf_clr);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge wr_clk) begin
      if (!reset && chk_en) begin
         check("cyc_address", 32'(bus.wr_address), 32'(m_writes % DEPTH));
         check("cyc_ptr", 32'(bus.wr_ptr), 32'(to_gray(m_writes)));
         check("cyc_full", 32'(bus.wr_full), 32'(m_full));
         check("cyc_afull", 32'(bus.wr_almost_full), 32'(m_afull));
         check("cyc_level", 32'(bus.wr_level), 32'(m_level));
         check("cyc_ack", 32'(bus.wr_ack), 32'(m_ack));
         check("cyc_ovf", 32'(bus.wr_overflow), 32'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge wr_clk);
      #2;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      rd_count    = 0;
      bus.wr_en   = 1'b0;
      bus.ovf_clr = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_address"}, 32'(bus.wr_address), 32'd0);
      check({tag, "_ptr"}, 32'(bus.wr_ptr), 32'd0);
      check({tag, "_full"}, 32'(bus.wr_full), 32'd0);
      check({tag, "_afull"}, 32'(bus.wr_almost_full), 32'd0);
      check({tag, "_level"}, 32'(bus.wr_level), 32'd0);
      check({tag, "_ack"}, 32'(bus.wr_ack), 32'd0);
      check({tag, "_ovf"}, 32'(bus.wr_overflow), 32'd0);
   endtask

   initial begin
      gray_tab = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
      n_cmp            = 0;
      n_fail           = 0;
      chk_en           = 1'b0;
      reset            = 1'b1;
      rd_count         = 0;
      bus.wr_en        = 1'b0;
      bus.ovf_clr      = 1'b0;
      bus.afull_thresh = 4'd6;
      #12;
      check_all_zero("reset");
      tick();
      reset  = 1'b0;
      chk_en = 1'b1;

      // 1: fill from empty
      bus.wr_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("fill_level", 32'(bus.wr_level), 32'(i));
         check("fill_ack", 32'(bus.wr_ack), 32'd1);
         check("fill_afull", 32'(bus.wr_almost_full), (i >= 6) ? 32'd1 : 32'd0);
      end
      check("fill_ptr", 32'(bus.wr_ptr), 32'b1100);
      check("fill_full", 32'(bus.wr_full), 32'd1);
      check("fill_address", 32'(bus.wr_address), 32'd0);

      // 2: writes while full
      for (int i = 0; i < 2; i++) begin
         tick();
         check("ovf_ptr_hold", 32'(bus.wr_ptr), 32'b1100);
         check("ovf_ack", 32'(bus.wr_ack), 32'd0);
         check("ovf_set", 32'(bus.wr_overflow), 32'd1);
      end
      bus.wr_en = 1'b0;
      tick();
      check("ovf_sticky", 32'(bus.wr_overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      tick();
      check("ovf_clear", 32'(bus.wr_overflow), 32'd0);

      // 5: set and clear in the same cycle, set wins
      bus.wr_en = 1'b1;
      tick();
      check("ovf_set_wins", 32'(bus.wr_overflow), 32'd1);
      bus.wr_en = 1'b0;
      tick();
      check("ovf_clear2", 32'(bus.wr_overflow), 32'd0);
      bus.ovf_clr = 1'b0;

      // 3: read pointer advances to 2
      rd_count = 2;
      tick();
      check("rd_full", 32'(bus.wr_full), 32'd0);
      check("rd_level", 32'(bus.wr_level), 32'd6);
      check("rd_afull", 32'(bus.wr_almost_full), 32'd1);
      bus.afull_thresh = 4'd7;
      tick();
      check("thresh7_afull", 32'(bus.wr_almost_full), 32'd0);
      bus.afull_thresh = 4'd6;
      tick();

      // 4: wrap with the read pointer trailing closely
      do_reset();
      bus.wr_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         check("wrap_ptr", 32'(bus.wr_ptr), 32'(gray_tab[k % 16]));
         check("wrap_address", 32'(bus.wr_address), 32'(k % DEPTH));
         check("wrap_full", 32'(bus.wr_full), 32'd0);
         check("wrap_level_le2", (bus.wr_level <= 4'd2) ? 32'd1 : 32'd0, 32'd1);
         rd_count = k - 1;
      end
      bus.wr_en = 1'b0;
      tick();

      // 6: asynchronous reset mid-fill
      do_reset();
      bus.wr_en = 1'b1;
      repeat (5) tick();
      check("mid_level", 32'(bus.wr_level), 32'd5);
      bus.wr_en = 1'b0;
      #1;
      reset    = 1'b1;
      rd_count = 0;
      #1;
      check_all_zero("async_rst");
      tick();
      reset = 1'b0;
      check("post_rst_address", 32'(bus.wr_address), 32'd0);
      bus.wr_en = 1'b1;
      tick();
      check("post_rst_ptr", 32'(bus.wr_ptr), 32'b0001);
      check("post_rst_ack", 32'(bus.wr_ack), 32'd1);
      bus.wr_en = 1'b0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
